// File: rtl/matmul_pkg.sv
// Shared types for the matmul_stream block: operating modes and FSM states.
package matmul_pkg;

    typedef enum logic [1:0] {
        MODE_A    = 2'd0,
        MODE_B    = 2'd1,
        MODE_DOT  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        CALC = 3'd3,
        OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/matmul_dot.sv
// Combinational unsigned dot product of two packed N-element vectors.
module matmul_dot #(
    parameter int unsigned N  = 32,
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 2 * DW + $clog2(N)
) (
    input  logic [N*DW-1:0] a_i,
    input  logic [N*DW-1:0] b_i,
    output logic [RW-1:0]   dot_o
);

    logic [RW-1:0] acc;

    // Accumulate element products; RW is wide enough that no term or sum wraps.
    always_comb begin
        acc = '0;
        for (int k = 0; k < int'(N); k++) begin
            acc = acc + RW'(a_i[k*DW +: DW]) * RW'(b_i[k*DW +: DW]);
        end
    end

    assign dot_o = acc;

endmodule

// File: rtl/matmul_stream.sv
// Streams one result per (row, col) of an N x N matrix: A, B transposed, or A*B.
module matmul_stream
    import matmul_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 2 * DW + $clog2(N)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [$clog2(N)-1:0]  req_row,
    output logic [$clog2(N)-1:0]  req_col,
    input  logic                  rsp_valid,
    input  logic [N*DW-1:0]       a_row,
    input  logic [N*DW-1:0]       b_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [$clog2(N)-1:0]  out_row,
    output logic [$clog2(N)-1:0]  out_col,
    output logic [RW-1:0]         out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t          state_q;
    mode_t           mode_q;
    logic            start_q;
    logic [IW-1:0]   row_q, col_q;
    logic [IW-1:0]   row_d, col_d;
    logic [N*DW-1:0] a_q, b_q;
    logic [RW-1:0]   dot_d;
    logic            req_valid_q, out_valid_q, busy_q, done_q, err_q;
    logic [IW-1:0]   req_row_q, req_col_q, out_row_q, out_col_q;
    logic [RW-1:0]   out_data_q;

    matmul_dot #(.N(N), .DW(DW), .RW(RW)) u_dot (
        .a_i   (a_q),
        .b_i   (b_q),
        .dot_o (dot_d)
    );

    // Row-major successor of the current index.
    always_comb begin
        row_d = row_q;
        col_d = col_q + IW'(1);
        if (col_q == LAST) begin
            col_d = '0;
            row_d = row_q + IW'(1);
        end
    end

    // Pass sequencer: one request, one response, one result per element.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            mode_q      <= MODE_A;
            start_q     <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            req_valid_q <= 1'b0;
            req_row_q   <= '0;
            req_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_q <= start;
            case (state_q)
                IDLE: begin
                    if (start && !start_q) begin
                        mode_q <= mode_t'(mode);
                        if (mode_t'(mode) != MODE_RSVD) begin
                            state_q     <= REQ;
                            row_q       <= '0;
                            col_q       <= '0;
                            req_valid_q <= 1'b1;
                            req_row_q   <= '0;
                            req_col_q   <= '0;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                            err_q       <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        a_q <= a_row;
                        b_q <= b_col;
                        if (mode_q == MODE_DOT) begin
                            state_q <= CALC;
                        end else begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                            out_row_q   <= row_q;
                            out_col_q   <= col_q;
                            out_data_q  <= (mode_q == MODE_A) ? RW'(a_row[int'(col_q)*DW +: DW])
                                                              : RW'(b_col[int'(row_q)*DW +: DW]);
                        end
                    end
                end
                CALC: begin
                    state_q     <= OUT;
                    out_valid_q <= 1'b1;
                    out_row_q   <= row_q;
                    out_col_q   <= col_q;
                    out_data_q  <= dot_d;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (row_q == LAST && col_q == LAST) begin
                            state_q <= IDLE;
                            row_q   <= '0;
                            col_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            row_q       <= row_d;
                            col_q       <= col_d;
                            req_valid_q <= 1'b1;
                            req_row_q   <= row_d;
                            req_col_q   <= col_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign req_row   = req_row_q;
    assign req_col   = req_col_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matmul_stream.sv
// Bench for matmul_stream (N=4, DW=8): randomized handshakes against a matrix-level model.
module tb_matmul_stream;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned RW = 2 * DW + IW;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [1:0]      mode;
    logic            req_valid, req_ready;
    logic [IW-1:0]   req_row, req_col;
    logic            rsp_valid;
    logic [N*DW-1:0] a_row, b_col;
    logic            out_valid, out_ready;
    logic [IW-1:0]   out_row, out_col;
    logic [RW-1:0]   out_data;
    logic            busy, done, err;

    matmul_stream #(.N(N), .DW(DW), .RW(RW)) dut (
        .clk_in    (clk),
        .rst_in    (rst_n),
        .start     (start),
        .mode      (mode),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_row   (req_row),
        .req_col   (req_col),
        .rsp_valid (rsp_valid),
        .a_row     (a_row),
        .b_col     (b_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // amem[r][k] = A[r][k]; bmem[c][k] = element k of the column vector served for column c
    logic [DW-1:0] amem [N][N];
    logic [DW-1:0] bmem [N][N];

    typedef struct {
        int     r;
        int     c;
        longint d;
    } exp_t;
    exp_t expq[$];

    int checks = 0;
    int passes = 0;
    int hs_cnt = 0;
    int hs_mode = 0;  // 0: all ready/valid high, 1: random, 2: out_ready toggles

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Operand memory: always serves the currently requested row/column
    always_comb begin
        a_row = '0;
        b_col = '0;
        for (int k = 0; k < int'(N); k++) begin
            a_row[k*DW +: DW] = amem[req_row][k];
            b_col[k*DW +: DW] = bmem[req_col][k];
        end
    end

    // Handshake input driver
    initial begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (hs_mode)
                1: begin
                    req_ready = 1'($urandom_range(0, 1));
                    rsp_valid = 1'($urandom_range(0, 1));
                    out_ready = 1'($urandom_range(0, 1));
                end
                2: begin
                    req_ready = 1'b1;
                    rsp_valid = 1'b1;
                    out_ready = ~out_ready;
                end
                default: begin
                    req_ready = 1'b1;
                    rsp_valid = 1'b1;
                    out_ready = 1'b1;
                end
            endcase
        end
    end

    // Output compare process: every presented result must match the head of the expectation queue
    logic          stalled_prev = 1'b0;
    logic [IW-1:0] prev_row, prev_col;
    logic [RW-1:0] prev_data;
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid || out_valid)
                check("req_out_exclusive", longint'(req_valid && out_valid), 0);
            if (out_valid) begin
                if (stalled_prev) begin
                    check("hold_row", out_row, prev_row);
                    check("hold_col", out_col, prev_col);
                    check("hold_data", out_data, prev_data);
                end
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL out_extra: got output (%0d,%0d)=%0d, expected none", out_row, out_col, out_data);
                end else begin
                    check("out_row", out_row, expq[0].r);
                    check("out_col", out_col, expq[0].c);
                    check("out_data", out_data, expq[0].d);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        hs_cnt++;
                    end
                end
            end
            stalled_prev <= out_valid && !out_ready;
            prev_row     <= out_row;
            prev_col     <= out_col;
            prev_data    <= out_data;
        end else begin
            stalled_prev <= 1'b0;
        end
    end

    task automatic randomize_mats();
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                amem[r][c] = DW'($urandom);
                bmem[r][c] = DW'($urandom);
            end
    endtask

    // Matrix-level model of one full pass in row-major order
    task automatic fill_model(input int m);
        exp_t e;
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                e.r = r;
                e.c = c;
                if (m == 0) e.d = longint'(amem[r][c]);
                else if (m == 1) e.d = longint'(bmem[c][r]);
                else begin
                    e.d = 0;
                    for (int k = 0; k < int'(N); k++)
                        e.d += longint'(amem[r][k]) * longint'(bmem[c][k]);
                end
                expq.push_back(e);
            end
    endtask

    task automatic do_start(input int m);
        @(posedge clk);
        #1;
        mode  = 2'(m);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic measure_latency(input int lat_req);
        int lat = 0;
        @(negedge clk);
        check("lat_req_valid", req_valid, 1);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, lat_req);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(done && !busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, longint'(n < 3000), 1);
        check({name, "_remaining"}, expq.size(), 0);
        check({name, "_done"}, done, 1);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic check_reset_values();
        check("rst_req_valid", req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        check("rst_req_row", req_row, 0);
        check("rst_req_col", req_col, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        exp_t e;
        int   base;
        int   n;
        bit   seen;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                amem[r][c] = '0;
                bmem[r][c] = '0;
            end
        repeat (3) @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Mode 0 with A[r][c]=4r+c, literal expectations, minimum latency 2
        hs_mode = 0;
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                amem[r][c] = DW'(4 * r + c);
                e.r = r; e.c = c; e.d = 4 * r + c;
                expq.push_back(e);
            end
        do_start(0);
        measure_latency(2);
        wait_done("mode0_ramp");

        // Mode 2 with all-255 operands: every result is 4*255*255 = 260100
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                amem[r][c] = 8'hFF;
                bmem[r][c] = 8'hFF;
                e.r = r; e.c = c; e.d = 260100;
                expq.push_back(e);
            end
        do_start(2);
        measure_latency(3);
        wait_done("mode2_max");

        // Mode 1 with out_ready toggling every cycle
        randomize_mats();
        fill_model(1);
        hs_mode = 2;
        do_start(1);
        wait_done("mode1_stall");

        // Reserved mode: error only, no pass; a later mode 0 start clears it
        hs_mode = 0;
        do_start(3);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (req_valid) seen = 1'b1;
        end
        check("rsvd_no_req", seen, 0);
        check("rsvd_err", err, 1);
        check("rsvd_busy", busy, 0);
        randomize_mats();
        fill_model(0);
        do_start(0);
        @(negedge clk);
        check("rsvd_err_cleared", err, 0);
        check("rsvd_restart_busy", busy, 1);
        check("restart_done_cleared", done, 0);
        wait_done("mode0_after_rsvd");

        // Randomized passes with random handshake timing
        for (int p = 0; p < 6; p++) begin
            int m = $urandom_range(0, 2);
            randomize_mats();
            fill_model(m);
            hs_mode = 1;
            do_start(m);
            wait_done($sformatf("rand_pass%0d_mode%0d", p, m));
        end

        // Reset after the 5th output of a mode 2 pass
        hs_mode = 0;
        randomize_mats();
        fill_model(2);
        base = hs_cnt;
        do_start(2);
        n = 0;
        while (hs_cnt < base + 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("midreset_reach5", longint'(n < 500), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        expq.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid || req_valid || busy) seen = 1'b1;
        end
        check("post_reset_silent", seen, 0);

        // Start held high, with an extra edge and a mode change mid-pass: one pass only
        randomize_mats();
        fill_model(0);
        base = hs_cnt;
        @(posedge clk);
        #1;
        mode  = 2'd0;
        start = 1'b1;
        n = 0;
        while (hs_cnt < base + 6 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'd2;
        @(posedge clk);
        #1 start = 1'b1;
        wait_done("held_start");
        repeat (30) @(negedge clk);
        check("held_start_outputs", hs_cnt - base, 16);
        check("held_start_idle", busy, 0);
        start = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matmul_stream.md
MATMUL_STREAM -- requirements
Module: matmul_stream

Interface
REQ-001 Parameter N, default 32, SHALL set the matrix dimension (N x N, N >= 2).
REQ-002 Parameter DW, default 8, SHALL set the element width in bits.
REQ-003 Parameter RW, default 2*DW+$clog2(N), SHALL set the result width.
REQ-004 clk_in  in  1  the single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 rst_in  in  1  reset, synchronous and active-low.
REQ-006 start  in  1  a rising edge begins a pass.
REQ-007 mode  in  2  0 = stream A, 1 = stream B transposed, 2 = A*B dot product, 3 = reserved.
REQ-008 req_valid / req_ready  out / in  1 / 1  operand request handshake.
REQ-009 req_row / req_col  out  $clog2(N) each  requested row of A and column of B.
REQ-010 rsp_valid  in  1  operand vectors valid this cycle.
REQ-011 a_row / b_col  in  N*DW each  packed operand vectors; element k is at bits [k*DW +: DW].
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 out_row / out_col  out  $clog2(N) each  result coordinates.
REQ-014 out_data  out  RW  result value.
REQ-015 busy / done / err  out  1 each  pass status.

Function
REQ-016 The block SHALL use states IDLE, REQ, WAIT, CALC and OUT.
REQ-017 IDLE: when start=1 and start was 0 in the previous cycle, mode SHALL be latched; if mode<3, go to REQ with index (0,0), done<=0, err<=0; if mode=3, set err<=1 and stay in IDLE.
REQ-018 REQ: req_valid=1 with req_row/req_col = current index; on req_ready=1, go to WAIT.
REQ-019 WAIT: on rsp_valid=1, capture a_row and b_col; go to CALC if the latched mode is 2, otherwise go to OUT; rsp_valid outside WAIT SHALL be ignored.
REQ-020 CALC: out_data SHALL be registered as sum over k of a_row[k]*b_col[k], all unsigned, with no overflow at RW bits; next state is OUT.
REQ-021 Mode 0: out_data = zero-extended a_row[col]. Mode 1: out_data = zero-extended b_col[row]. Both are registered on the WAIT-to-OUT transition.
REQ-022 OUT: out_valid=1, and out_row/out_col/out_data SHALL be held stable until out_ready=1.
REQ-023 On an OUT handshake, the index SHALL advance row-major: col+1; at col=N-1, col wraps to 0 and row increments.
REQ-024 On the OUT handshake of (N-1,N-1), the block SHALL go to IDLE and set done<=1 (sticky until the next accepted start).
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 start edges while busy SHALL be ignored; mode changes while busy SHALL have no effect.
REQ-027 Minimum latency SHALL be: REQ entry to out_valid of 2 cycles (modes 0/1) or 3 cycles (mode 2), given req_ready and rsp_valid asserted immediately.
REQ-028 req_valid and out_valid SHALL never be asserted in the same cycle, and at most one request SHALL be outstanding at a time.

Reset
REQ-029 With rst_in=0 at a clock edge, the block SHALL set state=IDLE, index=(0,0), req_valid=0, out_valid=0, out_data=0, out_row=out_col=0, req_row=req_col=0, done=0, err=0, busy=0, and the start history register=0.
REQ-030 A reset applied mid-pass SHALL abandon the pass; responses arriving afterwards SHALL be ignored, and no output SHALL be produced until a new start edge.

Structure
REQ-031 Package matmul_pkg SHALL hold the mode_t enum (MODE_A, MODE_B, MODE_DOT, MODE_RSVD) and the state_t enum.
REQ-032 The dot product SHALL be implemented in sub-module matmul_dot (parameters N, DW, RW), which is combinational; the result is registered in matmul_stream.

Verification (N=4, DW=8)
REQ-033 Stimulus: mode 0, A[r][c]=4r+c, req_ready, rsp_valid and out_ready tied high. Required response: 16 outputs in row-major order with out_data=4r+c, then done=1 and busy=0.
REQ-034 Stimulus: mode 2, A=all 255, B=all 255. Required response: every out_data=260100, with no truncation.
REQ-035 Stimulus: mode 1, out_ready toggling 0/1 each cycle. Required response: out_row/out_col/out_data held stable while stalled, and out_data=B[c][r] for every element.
REQ-036 Stimulus: mode 3 start edge. Required response: err=1, busy=0, no req_valid; a subsequent mode 0 start clears err.
REQ-037 Stimulus: rst_in=0 after the 5th output of a mode 2 pass. Required response: all outputs at reset values, and a late rsp_valid produces no output.
REQ-038 Stimulus: start held high throughout a pass, plus an extra start edge mid-pass. Required response: exactly one pass of 16 outputs.
